// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: pipeline port A has priority,
// loader/debug port B gets starvation relief and bounded locked bursts.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    typedef enum logic [0:0] {
        PRIO  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_next;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   burst_next;
    logic            grant_a;
    logic            grant_b;
    logic            locked;

    // Arbitration and next-state; grants are forced low while reset is held
    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        locked      = 1'b0;
        state_next  = PRIO;
        burst_next  = '0;
        starve_next = '0;
        if (rst) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end else begin
            locked = (state == BURST) && b_req && b_lock && (burst_cnt < BURST_TOP);
            if (locked) begin
                grant_b = 1'b1;
            end else if (b_req && (starve_cnt == STARVE_TOP)) begin
                grant_b = 1'b1;
            end else if (a_req) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b0;
            end

            // A fallback cycle out of a burst never re-locks while A is waiting
            if (locked) begin
                state_next = BURST;
                burst_next = burst_cnt + BW'(1);
            end else if (grant_b && b_lock && !((state == BURST) && a_req)) begin
                state_next = BURST;
                burst_next = BW'(1);
            end else begin
                state_next = PRIO;
                burst_next = '0;
            end

            if (grant_a && b_req) begin
                starve_next = (starve_cnt == STARVE_TOP) ? starve_cnt : starve_cnt + SW'(1);
            end else begin
                starve_next = '0;
            end
        end
    end

    // Arbiter state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PRIO;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            burst_cnt  <= burst_next;
        end
    end

    // Read-valid flags track the one-cycle memory latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= grant_a & ~a_we;
            b_rvalid <= grant_b & ~b_we;
        end
    end

    // Memory port follows whichever requester holds the grant
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_din  = '0;
        if (grant_a) begin
            mem_addr = a_addr;
            mem_we   = a_we;
            mem_din  = a_wdata;
        end else if (grant_b) begin
            mem_addr = b_addr;
            mem_we   = b_we;
            mem_din  = b_wdata;
        end else begin
            mem_addr = '0;
            mem_we   = 1'b0;
            mem_din  = '0;
        end
    end

    assign a_gnt   = grant_a;
    assign b_gnt   = grant_b;
    assign a_rdata = mem_dout;
    assign b_rdata = mem_dout;

endmodule
